// File: rtl/minisrc_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the single-bus Mini SRC datapath.
// A Moore step FSM (phase + 3-bit step counter T) drives every datapath strobe.
// Optional build macro SINGLE_STEP_EN adds a Step input: each instruction then
// waits in FETCH T0 for a rising edge of the registered Step.
module minisrc_control_unit #(
    parameter int         MEM_WAIT = 1,        // cycles a RAM read step is held (1..3)
    parameter logic [4:0] ADD_CODE = 5'b00011  // ALU code for address/target adds
) (
    input  logic       Clock,
    input  logic       Clear,
`ifdef SINGLE_STEP_EN
    input  logic       Step,
`endif
    input  logic [4:0] IR_Op,
    input  logic       ConFF_Out,
    input  logic       Stop,
    output logic       Run,
    output logic [4:0] CONTROL,
    output logic       PC_Out,
    output logic       MDR_Out,
    output logic       ZHI_Out,
    output logic       ZLO_Out,
    output logic       HI_Out,
    output logic       LO_Out,
    output logic       C_Out,
    output logic       InPort_Out,
    output logic       PC_In,
    output logic       MDR_In,
    output logic       MAR_In,
    output logic       IR_In,
    output logic       Y_In,
    output logic       ZHI_In,
    output logic       ZLO_In,
    output logic       HI_In,
    output logic       LO_In,
    output logic       InPort_In,
    output logic       OutPort_In,
    output logic       ConFF_In,
    output logic       IncPC,
    output logic       Read,
    output logic       Write,
    output logic       G_RA,
    output logic       G_RB,
    output logic       G_RC,
    output logic       R_In,
    output logic       R_Out,
    output logic       BA_Out
);

    typedef enum logic [1:0] {PH_RESET, PH_FETCH, PH_EXEC, PH_HALT} phase_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);

    phase_e     phase_q, phase_d;
    logic [2:0] t_q, t_d;
    logic [1:0] wcnt_q, wcnt_d;
    logic [4:0] op_q, op_d;
    logic       stop_q, stop_d;

    logic [4:0] op_eff;
    logic [2:0] last_t;
    logic       mem_step;
    logic       wait_done;
    logic       gate_wait;

`ifdef SINGLE_STEP_EN
    logic step_q, step_dly_q, armed_q, armed_d;
    logic step_edge;
`endif

    // Decode helpers: live opcode at T3 (IR just loaded), latched copy afterwards
    always_comb begin
        op_eff    = (phase_q == PH_EXEC && t_q == 3'd3) ? IR_Op : op_q;
        mem_step  = (phase_q == PH_FETCH && t_q == 3'd1) ||
                    (phase_q == PH_EXEC && t_q == 3'd6 && op_eff == OP_LD);
        wait_done = (wcnt_q == WAIT_LAST);
        last_t    = 3'd3;
        if (op_eff inside {[OP_ADD:OP_ORI]}) begin
            last_t = 3'd5;
        end else begin
            case (op_eff)
                OP_MUL, OP_DIV, OP_BR:   last_t = 3'd6;
                OP_NEG, OP_NOT, OP_JAL:  last_t = 3'd4;
                OP_LDI:                  last_t = 3'd5;
                OP_LD, OP_ST:            last_t = 3'd7;
                default:                 last_t = 3'd3;
            endcase
        end
`ifdef SINGLE_STEP_EN
        step_edge = step_q & ~step_dly_q;
        gate_wait = (phase_q == PH_FETCH && t_q == 3'd0 && !armed_q);
`else
        gate_wait = 1'b0;
`endif
    end

    // Next-state: phase/step sequencing, memory wait count, sticky Stop
    always_comb begin
        phase_d = phase_q;
        t_d     = t_q;
        wcnt_d  = wcnt_q;
        op_d    = op_q;
        stop_d  = stop_q;
`ifdef SINGLE_STEP_EN
        armed_d = armed_q;
`endif
        case (phase_q)
            PH_RESET: begin
                phase_d = PH_FETCH;
                t_d     = 3'd0;
                wcnt_d  = 2'd0;
                stop_d  = 1'b0;
`ifdef SINGLE_STEP_EN
                armed_d = 1'b0;
`endif
            end
            PH_FETCH, PH_EXEC: begin
                stop_d = stop_q | Stop;
                if (phase_q == PH_EXEC && t_q == 3'd3) op_d = IR_Op;
                if (gate_wait) begin
`ifdef SINGLE_STEP_EN
                    if (step_edge) armed_d = 1'b1;
`endif
                end else if (mem_step && !wait_done) begin
                    wcnt_d = wcnt_q + 2'd1;
                end else begin
                    wcnt_d = 2'd0;
                    if (phase_q == PH_FETCH) begin
`ifdef SINGLE_STEP_EN
                        if (t_q == 3'd0) armed_d = 1'b0;
`endif
                        if (t_q == 3'd2) begin
                            phase_d = PH_EXEC;
                            t_d     = 3'd3;
                        end else begin
                            t_d = t_q + 3'd1;
                        end
                    end else if (t_q == last_t) begin
                        t_d     = 3'd0;
                        stop_d  = 1'b0;
                        phase_d = (op_eff == OP_HALT || stop_q || Stop) ? PH_HALT : PH_FETCH;
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
            end
            default: begin
                // HALT: only Clear leaves
            end
        endcase
    end

    // State registers, asynchronously cleared by Clear
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            phase_q <= PH_RESET;
            t_q     <= 3'd0;
            wcnt_q  <= 2'd0;
            op_q    <= 5'd0;
            stop_q  <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_q     <= 1'b0;
            step_dly_q <= 1'b0;
            armed_q    <= 1'b0;
`endif
        end else begin
            phase_q <= phase_d;
            t_q     <= t_d;
            wcnt_q  <= wcnt_d;
            op_q    <= op_d;
            stop_q  <= stop_d;
`ifdef SINGLE_STEP_EN
            step_q     <= Step;
            step_dly_q <= step_q;
            armed_q    <= armed_d;
`endif
        end
    end

    // Moore outputs from phase, step and opcode; everything defaults low
    always_comb begin
        {Run, PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out} = '0;
        {PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In} = '0;
        {InPort_In, OutPort_In, ConFF_In, IncPC, Read, Write} = '0;
        {G_RA, G_RB, G_RC, R_In, R_Out, BA_Out} = '0;
        CONTROL = 5'd0;
        if (phase_q == PH_FETCH || phase_q == PH_EXEC) begin
            Run = 1'b1;
            if (!gate_wait) begin
                InPort_In = 1'b1;
                if (phase_q == PH_FETCH) begin
                    case (t_q)
                        3'd0:    {PC_Out, MAR_In, IncPC} = 3'b111;
                        3'd1:    {Read, MDR_In} = 2'b11;
                        default: {MDR_Out, IR_In} = 2'b11;
                    endcase
                end else if (op_eff inside {[OP_ADD:OP_ORI]}) begin
                    // reg-reg ALU ops and immediates share one skeleton
                    case (t_q)
                        3'd3: {G_RB, R_Out, Y_In} = 3'b111;
                        3'd4: begin
                            ZLO_In = 1'b1;
                            if (op_eff inside {[OP_ADD:OP_OR]}) begin
                                {G_RC, R_Out} = 2'b11;
                                CONTROL       = op_eff;
                            end else begin
                                C_Out = 1'b1;
                                case (op_eff)
                                    OP_ADDI: CONTROL = 5'b00011;
                                    OP_ANDI: CONTROL = 5'b01001;
                                    default: CONTROL = 5'b01010;
                                endcase
                            end
                        end
                        3'd5:    {ZLO_Out, G_RA, R_In} = 3'b111;
                        default: ;
                    endcase
                end else begin
                    case (op_eff)
                        OP_MUL, OP_DIV: begin
                            case (t_q)
                                3'd3: {G_RA, R_Out, Y_In} = 3'b111;
                                3'd4: begin
                                    {G_RB, R_Out, ZHI_In, ZLO_In} = 4'b1111;
                                    CONTROL = op_eff;
                                end
                                3'd5:    {ZLO_Out, LO_In} = 2'b11;
                                3'd6:    {ZHI_Out, HI_In} = 2'b11;
                                default: ;
                            endcase
                        end
                        OP_NEG, OP_NOT: begin
                            case (t_q)
                                3'd3: begin
                                    {G_RB, R_Out, ZLO_In} = 3'b111;
                                    CONTROL = op_eff;
                                end
                                3'd4:    {ZLO_Out, G_RA, R_In} = 3'b111;
                                default: ;
                            endcase
                        end
                        OP_LD, OP_LDI, OP_ST: begin
                            case (t_q)
                                3'd3: {G_RB, BA_Out, Y_In} = 3'b111;
                                3'd4: begin
                                    {C_Out, ZLO_In} = 2'b11;
                                    CONTROL = ADD_CODE;
                                end
                                3'd5: begin
                                    ZLO_Out = 1'b1;
                                    if (op_eff == OP_LDI) {G_RA, R_In} = 2'b11;
                                    else                  MAR_In = 1'b1;
                                end
                                3'd6: begin
                                    if (op_eff == OP_LD) {Read, MDR_In} = 2'b11;
                                    else                 {G_RA, R_Out, MDR_In} = 3'b111;
                                end
                                default: begin
                                    if (op_eff == OP_LD) {MDR_Out, G_RA, R_In} = 3'b111;
                                    else                 Write = 1'b1;
                                end
                            endcase
                        end
                        OP_BR: begin
                            case (t_q)
                                3'd3: {G_RA, R_Out, ConFF_In} = 3'b111;
                                3'd4: {PC_Out, Y_In} = 2'b11;
                                3'd5: begin
                                    {C_Out, ZLO_In} = 2'b11;
                                    CONTROL = ADD_CODE;
                                end
                                3'd6:    {ZLO_Out, PC_In} = {2{ConFF_Out}};
                                default: ;
                            endcase
                        end
                        OP_JR:   {G_RA, R_Out, PC_In} = 3'b111;
                        OP_JAL: begin
                            if (t_q == 3'd3) {PC_Out, G_RB, R_In} = 3'b111;
                            else             {G_RA, R_Out, PC_In} = 3'b111;
                        end
                        OP_IN:   {InPort_Out, G_RA, R_In} = 3'b111;
                        OP_OUT:  {G_RA, R_Out, OutPort_In} = 3'b111;
                        OP_MFHI: {HI_Out, G_RA, R_In} = 3'b111;
                        OP_MFLO: {LO_Out, G_RA, R_In} = 3'b111;
                        default: ; // nop, halt and undefined codes: idle step
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Directed bench for minisrc_control_unit: two instances (MEM_WAIT=1 and 2),
// outputs packed into one vector per instance and compared cycle by cycle.
module tb_minisrc_control_unit;

    logic       Clock = 1'b0;
    logic       Clear = 1'b0;
    logic       Stop = 1'b0;
    logic       ConFF_Out = 1'b0;
    logic       Step = 1'b0;
    logic [4:0] IR_Op = 5'b11001;
    logic [34:0] o1, o2;
    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    localparam logic [34:0] PCO  = 35'd1 << 0,  MDRO = 35'd1 << 1,  ZHIO = 35'd1 << 2;
    localparam logic [34:0] ZLOO = 35'd1 << 3,  HIO  = 35'd1 << 4,  LOO  = 35'd1 << 5;
    localparam logic [34:0] CO   = 35'd1 << 6,  INPO = 35'd1 << 7,  PCI  = 35'd1 << 8;
    localparam logic [34:0] MDRI = 35'd1 << 9,  MARI = 35'd1 << 10, IRI  = 35'd1 << 11;
    localparam logic [34:0] YIN  = 35'd1 << 12, ZHII = 35'd1 << 13, ZLOI = 35'd1 << 14;
    localparam logic [34:0] HII  = 35'd1 << 15, LOI  = 35'd1 << 16, INPI = 35'd1 << 17;
    localparam logic [34:0] OUTI = 35'd1 << 18, CFFI = 35'd1 << 19, INC  = 35'd1 << 20;
    localparam logic [34:0] RD   = 35'd1 << 21, WR   = 35'd1 << 22, GRA  = 35'd1 << 23;
    localparam logic [34:0] GRB  = 35'd1 << 24, GRC  = 35'd1 << 25, RIN  = 35'd1 << 26;
    localparam logic [34:0] ROUT = 35'd1 << 27, BAO  = 35'd1 << 28, RUN  = 35'd1 << 29;
    localparam logic [34:0] RI   = RUN | INPI;
    localparam logic [34:0] F0   = RI | PCO | MARI | INC;
    localparam logic [34:0] F1   = RI | RD | MDRI;
    localparam logic [34:0] F2   = RI | MDRO | IRI;

    function automatic logic [34:0] ctl(input logic [4:0] c);
        return {c, 30'd0};
    endfunction

    minisrc_control_unit #(.MEM_WAIT(1)) u_dut1 (
        .Clock(Clock), .Clear(Clear),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .IR_Op(IR_Op), .ConFF_Out(ConFF_Out), .Stop(Stop),
        .Run(o1[29]), .CONTROL(o1[34:30]),
        .PC_Out(o1[0]), .MDR_Out(o1[1]), .ZHI_Out(o1[2]), .ZLO_Out(o1[3]),
        .HI_Out(o1[4]), .LO_Out(o1[5]), .C_Out(o1[6]), .InPort_Out(o1[7]),
        .PC_In(o1[8]), .MDR_In(o1[9]), .MAR_In(o1[10]), .IR_In(o1[11]),
        .Y_In(o1[12]), .ZHI_In(o1[13]), .ZLO_In(o1[14]), .HI_In(o1[15]),
        .LO_In(o1[16]), .InPort_In(o1[17]), .OutPort_In(o1[18]), .ConFF_In(o1[19]),
        .IncPC(o1[20]), .Read(o1[21]), .Write(o1[22]), .G_RA(o1[23]),
        .G_RB(o1[24]), .G_RC(o1[25]), .R_In(o1[26]), .R_Out(o1[27]), .BA_Out(o1[28])
    );

    minisrc_control_unit #(.MEM_WAIT(2)) u_dut2 (
        .Clock(Clock), .Clear(Clear),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .IR_Op(IR_Op), .ConFF_Out(ConFF_Out), .Stop(Stop),
        .Run(o2[29]), .CONTROL(o2[34:30]),
        .PC_Out(o2[0]), .MDR_Out(o2[1]), .ZHI_Out(o2[2]), .ZLO_Out(o2[3]),
        .HI_Out(o2[4]), .LO_Out(o2[5]), .C_Out(o2[6]), .InPort_Out(o2[7]),
        .PC_In(o2[8]), .MDR_In(o2[9]), .MAR_In(o2[10]), .IR_In(o2[11]),
        .Y_In(o2[12]), .ZHI_In(o2[13]), .ZLO_In(o2[14]), .HI_In(o2[15]),
        .LO_In(o2[16]), .InPort_In(o2[17]), .OutPort_In(o2[18]), .ConFF_In(o2[19]),
        .IncPC(o2[20]), .Read(o2[21]), .Write(o2[22]), .G_RA(o2[23]),
        .G_RB(o2[24]), .G_RC(o2[25]), .R_In(o2[26]), .R_Out(o2[27]), .BA_Out(o2[28])
    );

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // one cycle later, compare instance 1 / instance 2
    task automatic exp1(input string tag, input logic [34:0] e);
        @(negedge Clock);
        chk(tag, o1, e);
    endtask

    task automatic exp2(input string tag, input logic [34:0] e);
        @(negedge Clock);
        chk(tag, o2, e);
    endtask

    task automatic fetch1(input string tag);
        exp1({tag, "_T0"}, F0);
        exp1({tag, "_T1"}, F1);
        exp1({tag, "_T2"}, F2);
    endtask

    // assert Clear, check outputs are all low, release on a falling edge
    task automatic do_reset();
        @(negedge Clock);
        Clear = 1'b0;
        #1;
        chk("rst_o1", o1, 35'd0);
        chk("rst_o2", o2, 35'd0);
        @(negedge Clock);
        Clear = 1'b1;
    endtask

    initial begin
        // add, MEM_WAIT=1: 6 steps; opcode changed after T4 must not matter
        IR_Op = 5'b00011;
        do_reset();
        fetch1("add");
        exp1("add_T3", RI | GRB | ROUT | YIN);
        exp1("add_T4", RI | GRC | ROUT | ZLOI | ctl(5'b00011));
        IR_Op = 5'b11010;
        exp1("add_T5", RI | ZLOO | GRA | RIN);
        exp1("add_next", F0);

        // ld on MEM_WAIT=2: read steps held two cycles, 10 cycles total
        IR_Op = 5'b00000;
        do_reset();
        exp2("ld_T0", F0);
        exp2("ld_T1a", F1);
        exp2("ld_T1b", F1);
        exp2("ld_T2", F2);
        exp2("ld_T3", RI | GRB | BAO | YIN);
        exp2("ld_T4", RI | CO | ZLOI | ctl(5'b00011));
        exp2("ld_T5", RI | ZLOO | MARI);
        exp2("ld_T6a", RI | RD | MDRI);
        exp2("ld_T6b", RI | RD | MDRI);
        exp2("ld_T7", RI | MDRO | GRA | RIN);
        exp2("ld_next", F0);

        // branch not taken then taken, back to back
        IR_Op = 5'b10010;
        ConFF_Out = 1'b0;
        do_reset();
        fetch1("brn");
        exp1("brn_T3", RI | GRA | ROUT | CFFI);
        exp1("brn_T4", RI | PCO | YIN);
        exp1("brn_T5", RI | CO | ZLOI | ctl(5'b00011));
        exp1("brn_T6", RI);
        exp1("brn_next", F0);
        ConFF_Out = 1'b1;
        exp1("brt_T1", F1);
        exp1("brt_T2", F2);
        exp1("brt_T3", RI | GRA | ROUT | CFFI);
        exp1("brt_T4", RI | PCO | YIN);
        exp1("brt_T5", RI | CO | ZLOI | ctl(5'b00011));
        exp1("brt_T6", RI | ZLOO | PCI);
        exp1("brt_next", F0);
        ConFF_Out = 1'b0;

        // mul with Stop pulsed at T4: finishes the instruction, then halts
        IR_Op = 5'b01110;
        do_reset();
        fetch1("mul");
        exp1("mul_T3", RI | GRA | ROUT | YIN);
        exp1("mul_T4", RI | GRB | ROUT | ZHII | ZLOI | ctl(5'b01110));
        Stop = 1'b1;
        exp1("mul_T5", RI | ZLOO | LOI);
        Stop = 1'b0;
        exp1("mul_T6", RI | ZHIO | HII);
        exp1("mul_halt0", 35'd0);
        exp1("mul_halt1", 35'd0);

        // st in full, then a second st reset at T6
        IR_Op = 5'b00010;
        do_reset();
        fetch1("st");
        exp1("st_T3", RI | GRB | BAO | YIN);
        exp1("st_T4", RI | CO | ZLOI | ctl(5'b00011));
        exp1("st_T5", RI | ZLOO | MARI);
        exp1("st_T6", RI | GRA | ROUT | MDRI);
        exp1("st_T7", RI | WR);
        exp1("st2_T0", F0);
        exp1("st2_T1", F1);
        exp1("st2_T2", F2);
        exp1("st2_T3", RI | GRB | BAO | YIN);
        exp1("st2_T4", RI | CO | ZLOI | ctl(5'b00011));
        exp1("st2_T5", RI | ZLOO | MARI);
        exp1("st2_T6", RI | GRA | ROUT | MDRI);
        #1;
        Clear = 1'b0;
        #1;
        chk("st2_clr", o1, 35'd0);
        @(negedge Clock);
        Clear = 1'b1;
        exp1("st_rel_T0", F0);

        // undefined opcode acts as nop: 4 cycles then next fetch
        IR_Op = 5'b11111;
        do_reset();
        fetch1("undef");
        exp1("undef_T3", RI);
        exp1("undef_next", F0);

        // halt: Run drops after T3 and stays low
        IR_Op = 5'b11010;
        do_reset();
        fetch1("halt");
        exp1("halt_T3", RI);
        for (int i = 0; i < 20; i++) exp1("halt_hold", 35'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
